// File: rtl/tree_poll_pkg.sv
// Shared types, defaults and width helper for the tree child poller.
// Latency: none (package only).
// Backpressure: none (package only).
package tree_poll_pkg;

    localparam int DEF_NUM_CHILDREN = 5;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_TIMEOUT      = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        GAP    = 2'd2,
        REPORT = 2'd3
    } poll_state_e;

    // Width that holds the sum of n words of w bits without overflow.
    function automatic int sum_width(input int n, input int w);
        return w + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tree_poll_timer.sv
// Loadable down-counter used as the per-child ack timeout.
// Latency: expire reflects the registered count (zero means expired).
// Backpressure: none; load beats clear, clear beats decrement.
module tree_poll_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Count down from the loaded value, saturating at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clear) begin
            cnt <= '0;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/tree_child_poller.sv
// Polls NUM_CHILDREN children in index order over req/ack and reports presence, XOR and sum.
// Latency: report valid 1+2*NUM_CHILDREN cycles after start with same-cycle acks; each silent child costs TIMEOUT+1.
// Backpressure: report held stable until rpt_ready_i; starts while busy are dropped. Optional macro TREE_POLL_PARITY_EN.
module tree_child_poller
    import tree_poll_pkg::*;
#(
    parameter  int NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int TIMEOUT      = DEF_TIMEOUT,
    localparam int SUM_W        = sum_width(NUM_CHILDREN, DATA_W)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    output logic                         busy_o,
    output logic [NUM_CHILDREN-1:0]      child_req_o,
    input  logic [NUM_CHILDREN-1:0]      child_ack_i,
    input  logic [NUM_CHILDREN*DATA_W-1:0] child_data_i,
`ifdef TREE_POLL_PARITY_EN
    input  logic [NUM_CHILDREN-1:0]      child_par_i,
`endif
    output logic                         rpt_valid_o,
    input  logic                         rpt_ready_i,
    output logic [NUM_CHILDREN-1:0]      rpt_present_o,
    output logic [DATA_W-1:0]            rpt_xor_o,
    output logic [SUM_W-1:0]             rpt_sum_o,
    output logic [NUM_CHILDREN-1:0]      rpt_parity_err_o
);

    localparam int IW = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    poll_state_e              state;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            next_idx;
    logic                     last_child;
    logic [DATA_W-1:0]        cur_data;
    logic                     cur_ack;
    logic                     tmr_load;
    logic                     tmr_clear;
    logic                     tmr_dec;
    logic                     tmr_expire;

    assign next_idx   = idx + IW'(1);
    assign last_child = (idx == IW'(NUM_CHILDREN - 1));
    assign cur_data   = child_data_i[idx*DATA_W +: DATA_W];
    assign cur_ack    = child_ack_i[idx];

    // The timer is reloaded every time a new child is requested; it only runs in REQ.
    assign tmr_load  = ((state == IDLE) && start_i) || ((state == GAP) && !last_child);
    assign tmr_clear = (state != REQ);
    assign tmr_dec   = (state == REQ);

    tree_poll_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .dec      (tmr_dec),
        .load_val (TW'(TIMEOUT - 1)),
        .expire   (tmr_expire)
    );

`ifdef TREE_POLL_PARITY_EN
    logic [NUM_CHILDREN-1:0] par_err;
    assign rpt_parity_err_o = par_err;
`else
    assign rpt_parity_err_o = '0;
`endif

    // Poll sequencer: walks the children, accumulates results, then holds the report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            busy_o        <= 1'b0;
            child_req_o   <= '0;
            rpt_valid_o   <= 1'b0;
            rpt_present_o <= '0;
            rpt_xor_o     <= '0;
            rpt_sum_o     <= '0;
`ifdef TREE_POLL_PARITY_EN
            par_err       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        rpt_present_o <= '0;
                        rpt_xor_o     <= '0;
                        rpt_sum_o     <= '0;
`ifdef TREE_POLL_PARITY_EN
                        par_err       <= '0;
`endif
                        idx           <= '0;
                        child_req_o   <= NUM_CHILDREN'(1);
                        busy_o        <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    // An ack on the timeout edge still counts.
                    if (cur_ack) begin
                        rpt_present_o[idx] <= 1'b1;
                        rpt_xor_o          <= rpt_xor_o ^ cur_data;
                        rpt_sum_o          <= rpt_sum_o + SUM_W'(cur_data);
`ifdef TREE_POLL_PARITY_EN
                        par_err[idx]       <= (^cur_data) ^ child_par_i[idx];
`endif
                        child_req_o        <= '0;
                        state              <= GAP;
                    end else if (tmr_expire) begin
                        child_req_o <= '0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (last_child) begin
                        rpt_valid_o <= 1'b1;
                        state       <= REPORT;
                    end else begin
                        idx         <= next_idx;
                        child_req_o <= NUM_CHILDREN'(1) << next_idx;
                        state       <= REQ;
                    end
                end
                REPORT: begin
                    if (rpt_ready_i) begin
                        rpt_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_child_poller.sv
// Randomized bench for tree_child_poller with a scoreboard queue and a decoupled report monitor.
// Latency: expected report cycle derived from per-child ack delays.
// Backpressure: rpt_ready_i stalled randomly and for long holds with dropped starts.
module tb_tree_child_poller;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int T  = 15;
    localparam int SW = W + $clog2(N + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             busy_o;
    logic [N-1:0]     child_req_o;
    logic [N-1:0]     child_ack_i = '0;
    logic [N*W-1:0]   child_data_i = '0;
    logic [N-1:0]     child_par_i = '0;
    logic             rpt_valid_o;
    logic             rpt_ready_i = 1'b0;
    logic [N-1:0]     rpt_present_o;
    logic [W-1:0]     rpt_xor_o;
    logic [SW-1:0]    rpt_sum_o;
    logic [N-1:0]     rpt_parity_err_o;

    tree_child_poller #(
        .NUM_CHILDREN (N),
        .DATA_W       (W),
        .TIMEOUT      (T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .child_req_o      (child_req_o),
        .child_ack_i      (child_ack_i),
        .child_data_i     (child_data_i),
`ifdef TREE_POLL_PARITY_EN
        .child_par_i      (child_par_i),
`endif
        .rpt_valid_o      (rpt_valid_o),
        .rpt_ready_i      (rpt_ready_i),
        .rpt_present_o    (rpt_present_o),
        .rpt_xor_o        (rpt_xor_o),
        .rpt_sum_o        (rpt_sum_o),
        .rpt_parity_err_o (rpt_parity_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0]  pres;
        logic [W-1:0]  x;
        logic [SW-1:0] s;
        logic [N-1:0]  perr;
        int            vcyc;
    } exp_t;

    exp_t sbq[$];

    // Per-child behaviour for the current poll: ack delay in cycles after req (>=T means silent).
    int           dly[N];
    logic [W-1:0] cdat[N];
    logic         cpar[N];
    logic         nforce[N];
    int           ccnt[N];
    bit           cwas[N];

    // Child models: ack after the configured delay, random noise on unrequested bits.
    initial begin
        logic [N-1:0]   a;
        logic [N*W-1:0] d;
        logic [N-1:0]   p;
        for (int i = 0; i < N; i++) begin
            ccnt[i] = 0; cwas[i] = 0; dly[i] = 0; cdat[i] = '0; cpar[i] = 0; nforce[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                d[i*W +: W] = W'($urandom);
                p[i] = 1'($urandom_range(0, 1));
                a[i] = 1'b0;
                if (rst) begin
                    ccnt[i] = 0;
                    cwas[i] = 0;
                end else if (child_req_o[i]) begin
                    if (ccnt[i] == dly[i]) begin
                        a[i] = 1'b1;
                        d[i*W +: W] = cdat[i];
                        p[i] = cpar[i];
                    end
                    ccnt[i]++;
                    cwas[i] = 1;
                end else begin
                    if (cwas[i])
                        chk($sformatf("req_len_c%0d", i), 64'(ccnt[i]), 64'((dly[i] < T) ? dly[i] + 1 : T));
                    cwas[i] = 0;
                    ccnt[i] = 0;
                    a[i] = nforce[i] | ($urandom_range(0, 2) == 0);
                end
            end
            child_ack_i  = a;
            child_data_i = d;
            child_par_i  = p;
        end
    end

    // Monitor: compares each report against the oldest expected entry.
    exp_t e;
    initial begin
        bit in_rpt;
        in_rpt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                in_rpt = 0;
            end else begin
                if (rpt_valid_o && !in_rpt) begin
                    in_rpt = 1;
                    if (sbq.size() == 0) begin
                        chk("unexpected_rpt", 1, 0);
                    end else begin
                        e = sbq[0];
                        chk("rpt_cycle", 64'(cyc), 64'(e.vcyc));
                        chk("rpt_present", 64'(rpt_present_o), 64'(e.pres));
                        chk("rpt_xor", 64'(rpt_xor_o), 64'(e.x));
                        chk("rpt_sum", 64'(rpt_sum_o), 64'(e.s));
                        chk("rpt_parity", 64'(rpt_parity_err_o), 64'(e.perr));
                        chk("rpt_busy", 64'(busy_o), 1);
                    end
                end
                if (rpt_valid_o && rpt_ready_i && in_rpt && sbq.size() > 0) begin
                    chk("hs_present", 64'(rpt_present_o), 64'(e.pres));
                    chk("hs_xor", 64'(rpt_xor_o), 64'(e.x));
                    chk("hs_sum", 64'(rpt_sum_o), 64'(e.s));
                    void'(sbq.pop_front());
                    in_rpt = 0;
                end
            end
        end
    end

    // Configure children for one poll, push the expected report, pulse start.
    // mode 0: all ack at once with 1..N; 1: child 2 silent, others FF; 2: random;
    // 3: child 0 sends 03 with par 1; 4: child 1 silent, child 4 noisy; 5: child 3 silent.
    task automatic issue(input int mode);
        exp_t x;
        int   total;
        for (int i = 0; i < N; i++) begin
            nforce[i] = 0;
            dly[i]    = 0;
            cdat[i]   = W'($urandom);
            cpar[i]   = ^cdat[i];
            case (mode)
                0: cdat[i] = W'(i + 1);
                1: begin cdat[i] = 8'hFF; cpar[i] = 0; if (i == 2) dly[i] = T + 3; end
                2: begin
                    dly[i]  = ($urandom_range(0, 3) == 0) ? T + $urandom_range(0, 2) : $urandom_range(0, 4);
                    cpar[i] = 1'($urandom_range(0, 1));
                end
                3: if (i == 0) begin cdat[i] = 8'h03; cpar[i] = 1; end
                4: begin if (i == 1) dly[i] = T + 1; if (i == 4) nforce[i] = 1; end
                5: if (i == 3) dly[i] = T + 2;
                default: ;
            endcase
        end
        x.pres = '0; x.x = '0; x.s = '0; x.perr = '0; total = 0;
        for (int i = 0; i < N; i++) begin
            if (dly[i] < T) begin
                x.pres[i] = 1'b1;
                x.x = x.x ^ cdat[i];
                x.s = x.s + SW'(cdat[i]);
`ifdef TREE_POLL_PARITY_EN
                x.perr[i] = (^cdat[i]) ^ cpar[i];
`endif
                total += dly[i] + 2;
            end else begin
                total += T + 1;
            end
        end
        x.vcyc = cyc + 1 + total;
        sbq.push_back(x);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("first_req_c0", 64'(child_req_o), 1);
        chk("busy_after_start", 64'(busy_o), 1);
    endtask

    // Wait for the report, stall ready for 'hold' cycles, then handshake.
    task automatic finish_rpt(input int hold, input bit poke);
        int n;
        bit seen;
        n = 0;
        while (!rpt_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rpt_valid_o) begin
            chk("rpt_wait_timeout", 0, 1);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            start_i = poke && (k == 5);
            @(negedge clk);
        end
        start_i     = poke;
        rpt_ready_i = 1'b1;
        @(negedge clk);
        rpt_ready_i = 1'b0;
        start_i     = 1'b0;
        chk("valid_drop_after_hs", 64'(rpt_valid_o), 0);
        chk("idle_after_hs", 64'(busy_o), 0);
        if (poke) begin
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy_o || (child_req_o != '0)) seen = 1;
            end
            chk("no_second_poll", 64'(seen), 0);
        end
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // Directed scenarios first, then randomized polls.
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy_o, child_req_o, rpt_valid_o, rpt_present_o, rpt_xor_o, rpt_sum_o, rpt_parity_err_o}, 0);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("idle_not_busy", 64'(busy_o), 0);

        issue(0); finish_rpt(0, 0);
        issue(1); finish_rpt(2, 0);
        issue(2); finish_rpt(20, 1);
        issue(4); finish_rpt(1, 0);
        issue(3); finish_rpt(0, 0);

        // Reset in the middle of polling child 3.
        issue(5);
        n = 0;
        while (child_req_o != 5'b01000 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_child3", 64'(child_req_o), 64'(5'b01000));
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("midpoll_reset_outputs", {busy_o, child_req_o, rpt_valid_o, rpt_present_o, rpt_xor_o, rpt_sum_o, rpt_parity_err_o}, 0);
        void'(sbq.pop_back());
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        issue(0); finish_rpt(1, 0);

        for (int r = 0; r < 40; r++) begin
            issue(2);
            finish_rpt($urandom_range(0, 3), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 0);
        summary();
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        summary();
        $fatal(1);
    end

endmodule
